// File: rtl/crc32_serial_checker.sv
`default_nettype none
// ============================================================================
// crc32_serial_checker : serial CRC-32 receive-side checker, MSB-first frames
// Revision 1.0
// ============================================================================
module crc32_serial_checker #(
  parameter logic [31:0] POLY    = 32'h04C11DB7,
  parameter logic [31:0] INIT    = 32'h00000000,
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             din,
  input  logic             din_valid,
  input  logic             d_finish,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done,
  output logic             crc_ok,
  output logic             crc_err,
  output logic             timeout,
  output logic [31:0]      calc_crc,
  output logic [31:0]      rx_crc,
  output logic [LEN_W-1:0] payload_len
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DATA  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int unsigned       IDLE_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  state_t             state_q;
  logic [31:0]        crc_q;
  logic [31:0]        calc_crc_q;
  logic [31:0]        rx_crc_q;
  logic [LEN_W-1:0]   payload_len_q;
  logic [4:0]         crc_cnt_q;
  logic [IDLE_W-1:0]  idle_cnt_q;
  logic               dout_q;
  logic               dout_valid_q;
  logic               busy_q;
  logic               done_q;
  logic               crc_ok_q;
  logic               crc_err_q;
  logic               timeout_q;

  logic [31:0]        crc_d;
  logic [31:0]        rx_crc_d;
  logic               timeout_hit;

  assign crc_d       = {crc_q[30:0], 1'b0} ^ ((crc_q[31] ^ din) ? POLY : 32'h0);
  assign rx_crc_d    = {rx_crc_q[30:0], din};
  // The idle cycle that would make the count reach TIMEOUT ends the frame.
  assign timeout_hit = (TIMEOUT != 0) && !din_valid && (idle_cnt_q == IDLE_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      crc_q         <= INIT;
      calc_crc_q    <= '0;
      rx_crc_q      <= '0;
      payload_len_q <= '0;
      crc_cnt_q     <= '0;
      idle_cnt_q    <= '0;
      dout_q        <= 1'b0;
      dout_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      crc_ok_q      <= 1'b0;
      crc_err_q     <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      dout_valid_q <= 1'b0;
      done_q       <= 1'b0;
      if (load) begin
        // Frame start from any state; an in-flight frame is silently dropped.
        state_q       <= S_DATA;
        busy_q        <= 1'b1;
        crc_q         <= INIT;
        rx_crc_q      <= '0;
        payload_len_q <= '0;
        crc_cnt_q     <= '0;
        idle_cnt_q    <= '0;
        crc_ok_q      <= 1'b0;
        crc_err_q     <= 1'b0;
        timeout_q     <= 1'b0;
      end else begin
        case (state_q)
          S_DATA, S_CHECK: begin
            if (din_valid) begin
              idle_cnt_q <= '0;
              if (state_q == S_DATA) begin
                crc_q        <= crc_d;
                dout_q       <= din;
                dout_valid_q <= 1'b1;
                if (payload_len_q != {LEN_W{1'b1}}) begin
                  payload_len_q <= payload_len_q + 1'b1;
                end
                if (d_finish) begin
                  calc_crc_q <= crc_d;
                  state_q    <= S_CHECK;
                end
              end else begin
                rx_crc_q  <= rx_crc_d;
                crc_cnt_q <= crc_cnt_q + 1'b1;
                if (crc_cnt_q == 5'd31) begin
                  crc_ok_q  <= (calc_crc_q == rx_crc_d);
                  crc_err_q <= (calc_crc_q != rx_crc_d);
                  done_q    <= 1'b1;
                  busy_q    <= 1'b0;
                  state_q   <= S_DONE;
                end
              end
            end else if (timeout_hit) begin
              crc_ok_q  <= 1'b0;
              crc_err_q <= 1'b1;
              timeout_q <= 1'b1;
              done_q    <= 1'b1;
              busy_q    <= 1'b0;
              state_q   <= S_DONE;
            end else begin
              idle_cnt_q <= idle_cnt_q + 1'b1;
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign dout        = dout_q;
  assign dout_valid  = dout_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign crc_ok      = crc_ok_q;
  assign crc_err     = crc_err_q;
  assign timeout     = timeout_q;
  assign calc_crc    = calc_crc_q;
  assign rx_crc      = rx_crc_q;
  assign payload_len = payload_len_q;

endmodule
`default_nettype wire

// File: tb/tb_crc32_serial_checker.sv
`default_nettype none
// ============================================================================
// tb_crc32_serial_checker : randomized self-checking bench, long-division model
// Revision 1.0
// ============================================================================
module tb_crc32_serial_checker;

  localparam logic [31:0] POLY  = 32'h04C11DB7;
  localparam int unsigned LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             load = 1'b0;
  logic             din = 1'b0;
  logic             din_valid = 1'b0;
  logic             d_finish = 1'b0;
  logic             dout, dout_valid, busy, done, crc_ok, crc_err, timeout;
  logic [31:0]      calc_crc, rx_crc;
  logic [LEN_W-1:0] payload_len;

  int total = 0;
  int bad   = 0;
  int dv_cnt = 0;
  int done_cnt = 0;
  bit dq[$];

  crc32_serial_checker #(
    .POLY(POLY), .INIT(32'h0), .LEN_W(LEN_W), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .din(din), .din_valid(din_valid),
    .d_finish(d_finish), .dout(dout), .dout_valid(dout_valid), .busy(busy),
    .done(done), .crc_ok(crc_ok), .crc_err(crc_err), .timeout(timeout),
    .calc_crc(calc_crc), .rx_crc(rx_crc), .payload_len(payload_len)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dout_valid) begin
      dv_cnt++;
      dq.push_back(dout);
    end
    if (done) done_cnt++;
  end

  // Remainder of M(x)*x^32 divided by P(x), by plain long division.
  function automatic logic [31:0] crc_ref(input bit m[$]);
    logic [32:0] rem;
    bit b;
    rem = '0;
    for (int i = 0; i < m.size() + 32; i++) begin
      b = (i < m.size()) ? m[i] : 1'b0;
      rem = {rem[31:0], b};
      if (rem[32]) rem = rem ^ {1'b1, POLY};
    end
    return rem[31:0];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // gap < 0 selects a random 0..3 idle cycles before every bit.
  task automatic drive_frame(input bit p[$], input logic [31:0] rx, input int gap);
    int g;
    load = 1'b1; din_valid = 1'b0; tick;
    load = 1'b0;
    dq.delete();
    for (int i = 0; i < p.size(); i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      din_valid = 1'b0;
      repeat (g) tick;
      din_valid = 1'b1; din = p[i]; d_finish = (i == p.size() - 1);
      tick;
    end
    d_finish = 1'b0;
    for (int j = 31; j >= 0; j--) begin
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      din_valid = 1'b0;
      repeat (g) tick;
      din_valid = 1'b1; din = rx[j];
      tick;
    end
    din_valid = 1'b0; din = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) tick;
    total++; if ({dout, dout_valid, busy, done, crc_ok, crc_err, timeout} !== 7'b0) begin bad++; $display("FAIL reset_flags got %b want 0", {dout, dout_valid, busy, done, crc_ok, crc_err, timeout}); end
    total++; if ({calc_crc, rx_crc, payload_len} !== '0) begin bad++; $display("FAIL reset_data got %h want 0", {calc_crc, rx_crc, payload_len}); end
    rst = 1'b1;
    tick;
  endtask

  task automatic test_single_bit;
    bit p[$];
    int d0;
    p = '{1'b1};
    d0 = done_cnt;
    drive_frame(p, 32'h04C11DB7, 0);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL single_done got %b want 1", done); end
    total++; if (calc_crc !== 32'h04C11DB7) begin bad++; $display("FAIL single_calc got %h want 04c11db7", calc_crc); end
    total++; if (calc_crc !== crc_ref(p)) begin bad++; $display("FAIL single_model got %h want %h", calc_crc, crc_ref(p)); end
    total++; if ({crc_ok, crc_err, timeout} !== 3'b100) begin bad++; $display("FAIL single_flags got %b want 100", {crc_ok, crc_err, timeout}); end
    total++; if (payload_len !== 16'd1) begin bad++; $display("FAIL single_len got %0d want 1", payload_len); end
    tick;
    total++; if (done !== 1'b0 || done_cnt !== d0 + 1) begin bad++; $display("FAIL single_pulse got done=%b cnt=%0d want 0/%0d", done, done_cnt - d0, 1); end
    total++; if (crc_ok !== 1'b1) begin bad++; $display("FAIL single_hold got %b want 1", crc_ok); end
  endtask

  task automatic test_two_bit;
    bit p[$];
    p = '{1'b1, 1'b0};
    drive_frame(p, 32'h09823B6E, -1);
    total++; if ({done, crc_ok, crc_err} !== 3'b110) begin bad++; $display("FAIL two_ok got %b want 110", {done, crc_ok, crc_err}); end
    total++; if (calc_crc !== crc_ref(p)) begin bad++; $display("FAIL two_model got %h want %h", calc_crc, crc_ref(p)); end
    tick;
    drive_frame(p, 32'h09823B6F, -1);
    total++; if ({done, crc_ok, crc_err, timeout} !== 4'b1010) begin bad++; $display("FAIL two_err got %b want 1010", {done, crc_ok, crc_err, timeout}); end
    total++; if (rx_crc !== 32'h09823B6F) begin bad++; $display("FAIL two_rx got %h want 09823b6f", rx_crc); end
    tick;
  endtask

  task automatic test_zero_toggle;
    bit p[$];
    int dv0;
    for (int i = 0; i < 64; i++) p.push_back(1'b0);
    dv0 = dv_cnt;
    drive_frame(p, 32'h0, 1);
    total++; if ({done, crc_ok, crc_err} !== 3'b110) begin bad++; $display("FAIL zero_ok got %b want 110", {done, crc_ok, crc_err}); end
    total++; if (calc_crc !== 32'h0) begin bad++; $display("FAIL zero_calc got %h want 0", calc_crc); end
    total++; if (payload_len !== 16'd64) begin bad++; $display("FAIL zero_len got %0d want 64", payload_len); end
    total++; if (dv_cnt - dv0 !== 64) begin bad++; $display("FAIL zero_dvcount got %0d want 64", dv_cnt - dv0); end
    tick;
  endtask

  task automatic test_timeout;
    int early;
    load = 1'b1; tick; load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      din_valid = 1'b1; din = 1'($urandom_range(0, 1)); tick;
    end
    din_valid = 1'b0;
    early = 0;
    repeat (7) begin
      tick;
      if (done) early++;
    end
    total++; if (early !== 0 || busy !== 1'b1) begin bad++; $display("FAIL tmo_early got done_cycles=%0d busy=%b want 0/1", early, busy); end
    tick;
    total++; if ({done, crc_ok, crc_err, timeout} !== 4'b1011) begin bad++; $display("FAIL tmo_flags got %b want 1011", {done, crc_ok, crc_err, timeout}); end
    total++; if (payload_len !== 16'd5) begin bad++; $display("FAIL tmo_len got %0d want 5", payload_len); end
    tick;
    total++; if ({busy, done, timeout} !== 3'b001) begin bad++; $display("FAIL tmo_after got %b want 001", {busy, done, timeout}); end
  endtask

  task automatic test_abort;
    bit pa[$], pb[$];
    int d0;
    for (int i = 0; i < 8; i++) pa.push_back(1'($urandom_range(0, 1)));
    for (int i = 0; i < 12; i++) pb.push_back(1'($urandom_range(0, 1)));
    d0 = done_cnt;
    load = 1'b1; tick; load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      din_valid = 1'b1; din = pa[i]; d_finish = (i == 7); tick;
    end
    d_finish = 1'b0;
    for (int i = 0; i < 10; i++) begin
      din_valid = 1'b1; din = 1'($urandom_range(0, 1)); tick;
    end
    din_valid = 1'b0;
    drive_frame(pb, crc_ref(pb), -1);
    total++; if ({done, crc_ok, crc_err} !== 3'b110) begin bad++; $display("FAIL abort_b got %b want 110", {done, crc_ok, crc_err}); end
    total++; if (payload_len !== 16'd12) begin bad++; $display("FAIL abort_len got %0d want 12", payload_len); end
    tick;
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL abort_dones got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid;
    bit p[$];
    load = 1'b1; tick; load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      din_valid = 1'b1; din = 1'b1; tick;
    end
    din_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    total++; if ({dout, dout_valid, busy, done, crc_ok, crc_err, timeout, calc_crc, rx_crc, payload_len} !== '0) begin bad++; $display("FAIL rstmid_async got busy=%b len=%0d want all 0", busy, payload_len); end
    tick; tick;
    rst = 1'b1;
    tick;
    for (int i = 0; i < 20; i++) p.push_back(1'($urandom_range(0, 1)));
    drive_frame(p, crc_ref(p), -1);
    total++; if ({done, crc_ok, crc_err} !== 3'b110 || calc_crc !== crc_ref(p)) begin bad++; $display("FAIL rstmid_frame got %b %h want 110 %h", {done, crc_ok, crc_err}, calc_crc, crc_ref(p)); end
    tick;
  endtask

  task automatic test_random;
    bit p[$];
    logic [31:0] ref_crc, rx;
    int len, dv0, mism;
    bit good;
    for (int f = 0; f < 8; f++) begin
      dv0 = dv_cnt;
      repeat (3) begin
        din_valid = 1'b1; din = 1'b1; d_finish = 1'($urandom_range(0, 1)); tick;
      end
      din_valid = 1'b0; d_finish = 1'b0;
      total++; if (busy !== 1'b0 || dv_cnt !== dv0) begin bad++; $display("FAIL rnd_idle_ignored got busy=%b dv=%0d want 0/0", busy, dv_cnt - dv0); end
      p.delete();
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) p.push_back(1'($urandom_range(0, 1)));
      ref_crc = crc_ref(p);
      good = 1'($urandom_range(0, 1));
      rx = good ? ref_crc : (ref_crc ^ (32'h1 << $urandom_range(0, 31)));
      drive_frame(p, rx, -1);
      total++; if ({done, crc_ok, crc_err, timeout} !== {1'b1, good, !good, 1'b0}) begin bad++; $display("FAIL rnd_flags frame %0d got %b want %b", f, {done, crc_ok, crc_err, timeout}, {1'b1, good, !good, 1'b0}); end
      total++; if (calc_crc !== ref_crc || rx_crc !== rx) begin bad++; $display("FAIL rnd_crc frame %0d got %h/%h want %h/%h", f, calc_crc, rx_crc, ref_crc, rx); end
      total++; if (payload_len !== 16'(len)) begin bad++; $display("FAIL rnd_len frame %0d got %0d want %0d", f, payload_len, len); end
      mism = (dq.size() != len) ? 1 : 0;
      for (int i = 0; i < dq.size() && i < len; i++) if (dq[i] != p[i]) mism = 1;
      total++; if (mism !== 0) begin bad++; $display("FAIL rnd_dout frame %0d got %0d bits want %0d matching", f, dq.size(), len); end
      tick;
    end
  endtask

  initial begin
    test_reset;
    test_single_bit;
    test_two_bit;
    test_zero_toggle;
    test_timeout;
    test_abort;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/crc32_serial_checker.md
Name: crc32_serial_checker

Overview:
Serial CRC-32 receiver/checker. It is the receive-side counterpart of the team's serial CRC-32 generator, which sends payload bits MSB-first followed by 32 CRC bits (CRC MSB first).
- Recomputes the CRC over the incoming payload bits and forwards those bits downstream.
- Captures the trailing 32 received CRC bits and compares them against the computed value.
- Reports the result with a done pulse plus ok/err flags.
- Sits at the serial link input, ahead of the frame deserializer.

Parameters:
POLY, 32'h04C11DB7, generator polynomial (normal form; x^32 implicit)
INIT, 32'h00000000, LFSR value loaded at frame start (no reflection, no final XOR)
LEN_W, 16, width of payload bit counter
TIMEOUT, 1024, max consecutive cycles without din_valid inside a frame; 0 disables

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
load  input  1  frame start pulse; carries no data bit
din  input  1  serial bit
din_valid  input  1  din qualifier
d_finish  input  1  marks last payload bit; only honoured with din_valid in DATA
dout  output  1  forwarded payload bit (registered)
dout_valid  output  1  dout qualifier
busy  output  1  high in DATA or CHECK
done  output  1  one-cycle result strobe
crc_ok  output  1  frame CRC matched; held until next load
crc_err  output  1  mismatch or timeout; held until next load
timeout  output  1  frame aborted by timeout; held until next load
calc_crc  output  32  CRC computed over payload
rx_crc  output  32  CRC bits received
payload_len  output  LEN_W  payload bits received; saturates at all-ones

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs 0. LFSR=INIT. All counters 0.
- LFSR step on each accepted bit: fb=crc[31]^din; crc <= {crc[30:0],1'b0} ^ (fb ? POLY : 0).
- States and transitions:
  - IDLE:
    - load=1 -> DATA.
    - On entering DATA: LFSR=INIT; payload_len, crc_cnt, idle_cnt, rx_crc cleared; crc_ok, crc_err, timeout cleared.
  - DATA, on din_valid=1:
    - LFSR step.
    - dout<=din and dout_valid<=1, one cycle after acceptance.
    - payload_len++ (saturating).
    - If d_finish=1 on the same cycle -> CHECK, and calc_crc latches the post-step LFSR value.
    - dout_valid=0 on cycles with no accepted payload bit.
  - CHECK, on din_valid=1:
    - rx_crc <= {rx_crc[30:0],din}; crc_cnt++.
    - On the 32nd bit (crc_cnt==31): crc_ok = (calc_crc == {rx_crc[30:0],din}), crc_err = its inverse, then -> DONE.
    - d_finish is ignored.
  - DONE: done=1 for exactly one cycle -> IDLE. dout_valid=0.
- Result latency: done and the flags are valid the cycle after the final CRC bit is accepted.
- Timeout:
  - idle_cnt counts consecutive cycles in DATA/CHECK with din_valid=0; it resets on any valid bit.
  - When idle_cnt reaches TIMEOUT (TIMEOUT≠0): -> DONE with crc_err=1, timeout=1, crc_ok=0.
- load while in DATA or CHECK: frame aborts and restarts, behaving as the IDLE->DATA entry. No done is issued for the aborted frame.
- load in DONE: takes priority; goes directly to DATA, and the done pulse still occurs that cycle.
- d_finish without din_valid: ignored.
- Payload must be ≥1 bit.
- din_valid in IDLE: ignored.
- rst asserted mid-frame: immediate return to reset values; no done.

Test Plan:
- Single payload bit 1 with d_finish, then CRC bits 32'h04C11DB7 -> calc_crc=32'h04C11DB7, done one cycle after the 32nd CRC bit, crc_ok=1, payload_len=1.
- Payload "10", then rx CRC 32'h09823B6E -> crc_ok=1. Repeat with rx CRC 32'h09823B6F -> crc_err=1, rx_crc=32'h09823B6F.
- 64 zero payload bits with din_valid toggling every other cycle, then 32 zero CRC bits -> calc_crc=0, crc_ok=1, payload_len=64, and dout_valid pulses exactly 64 times.
- TIMEOUT=8: stop din_valid after 5 payload bits -> 8 idle cycles later, done=1 with crc_err=1 and timeout=1; busy=0 next cycle.
- load reasserted after 10 CRC bits of frame A, then a valid frame B -> no done for A; B reports crc_ok=1.
- rst low mid-DATA -> all outputs 0 immediately, state IDLE; a subsequent full frame checks correctly.
